// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4-channel mux scan controller and its channel lookup helper.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_scan_ctrl_next_ch.sv
// Channel lookup: lowest enabled channel (first) or lowest enabled channel above cur.
module mux4_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_cur,
  input  logic              i_first,
  output logic [SEL_W-1:0]  o_next,
  output logic              o_has_next
);

  // Descending walk so the lowest qualifying index is the one left standing.
  always_comb begin
    o_next     = '0;
    o_has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
        o_next     = SEL_W'(i);
        o_has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scans enabled channels of a downstream 4:1 mux, dwelling on each before sampling,
// and presents the assembled 4-bit word with a one-cycle valid pulse.
module mux4_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic [3:0]  ch_mask,
  input  logic        mux_out,
  output logic [1:0]  sel,
  output logic [3:0]  sample_word,
  output logic        word_valid,
  output logic        busy
);

  state_t             r_state;
  logic [NUM_CH-1:0]  r_mask;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_CH-1:0]  r_shadow;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_CH-1:0]  r_word;
  logic               r_valid;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [NUM_CH-1:0]  w_mask_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_CH-1:0]  w_shadow_nxt;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [NUM_CH-1:0]  w_word_nxt;
  logic               w_valid_nxt;
  logic               w_busy_nxt;

  logic [SEL_W-1:0]   w_first_idx;
  logic               w_first_ok;
  logic [SEL_W-1:0]   w_next_idx;
  logic               w_has_next;
  logic               w_dwell_done;
  logic [NUM_CH-1:0]  w_sampled;

  // Lookup on the live mask serves both the initial start and continuous restarts.
  mux4_next_ch u_first (
    .i_mask     (ch_mask),
    .i_cur      ('0),
    .i_first    (1'b1),
    .o_next     (w_first_idx),
    .o_has_next (w_first_ok)
  );

  mux4_next_ch u_next (
    .i_mask     (r_mask),
    .i_cur      (r_sel),
    .i_first    (1'b0),
    .o_next     (w_next_idx),
    .o_has_next (w_has_next)
  );

  assign w_dwell_done = (r_cnt == CNT_W'(DWELL - 1));

  always_comb begin
    w_sampled        = r_shadow;
    w_sampled[r_sel] = mux_out;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_sel_nxt    = r_sel;
    w_word_nxt   = r_word;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_first_ok) begin
            w_state_nxt  = SCAN;
            w_mask_nxt   = ch_mask;
            w_sel_nxt    = w_first_idx;
            w_cnt_nxt    = '0;
            w_shadow_nxt = '0;
            w_busy_nxt   = 1'b1;
          end else begin
            // Empty mask still answers with an (all-zero) word so callers never stall.
            w_word_nxt  = '0;
            w_valid_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        if (w_dwell_done) begin
          w_cnt_nxt = '0;
          if (w_has_next) begin
            w_shadow_nxt = w_sampled;
            w_sel_nxt    = w_next_idx;
          end else begin
            w_word_nxt   = w_sampled;
            w_valid_nxt  = 1'b1;
            w_shadow_nxt = '0;
            if (continuous) begin
              w_mask_nxt = ch_mask;
            end
            if (continuous && w_first_ok) begin
              w_sel_nxt = w_first_idx;
            end else begin
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_sel    <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask   <= w_mask_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_sel    <= w_sel_nxt;
      r_word   <= w_word_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign sel         = r_sel;
  assign sample_word = r_word;
  assign word_valid  = r_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: vector table, hand-written corner sequences, random scans.
module tb_mux4_scan_ctrl;

  localparam int DW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       continuous;
  logic [3:0] ch_mask;
  logic [3:0] r_in;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] sample_word;
  logic       word_valid;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux driven by the controller's select.
  assign mux_out = r_in[sel];

  mux4_scan_ctrl #(.DWELL(DW), .CNT_W(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .ch_mask     (ch_mask),
    .mux_out     (mux_out),
    .sel         (sel),
    .sample_word (sample_word),
    .word_valid  (word_valid),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [3:0] din;
    logic [3:0] word;
    int         lat;
  } vec_t;

  // Single-shot scan; expectation of sel order derived from the mask, a stray start
  // and a mask change are injected mid-scan and must have no effect.
  task automatic run_scan(input string tag, input logic [3:0] m, input logic [3:0] v,
                          input logic [3:0] exp_word, input int exp_lat);
    int         ch[$];
    int         k;
    int         got_lat;
    int         sel_err;
    int         extra;
    logic [3:0] got_word;
    logic       got_busy;
    for (int i = 0; i < 4; i++) if (m[i]) ch.push_back(i);
    @(negedge clk);
    start   = 1'b1;
    ch_mask = m;
    r_in    = v;
    @(posedge clk);
    got_lat  = -1;
    got_word = 'x;
    got_busy = 'x;
    sel_err  = 0;
    k        = 0;
    while (k <= 100) begin
      @(negedge clk);
      if (word_valid) begin
        got_lat  = k;
        got_word = sample_word;
        got_busy = busy;
        break;
      end
      if (k < ch.size() * DW && sel !== ch[k / DW][1:0]) sel_err++;
      start   = (k == 1 && exp_lat >= 4);
      ch_mask = ~m;
      k++;
    end
    start = 1'b0;
    check({tag, "_latency"}, got_lat, exp_lat);
    check({tag, "_word"}, got_word, exp_word);
    check({tag, "_busy_end"}, got_busy, 1'b0);
    extra = 0;
    repeat (2 * DW + 2) begin
      @(negedge clk);
      if (word_valid) extra++;
    end
    check({tag, "_extra_valid"}, extra, 0);
    if (ch.size() > 0) begin
      check({tag, "_sel_walk"}, sel_err, 0);
      check({tag, "_sel_hold"}, sel, ch[ch.size() - 1]);
    end
    ch_mask = '0;
  endtask

  vec_t vecs[6];

  initial begin
    int         idle_err;
    int         nv;
    int         k1, k2, rv;
    logic [3:0] w1, w2;
    logic       b1, b2;
    logic [1:0] s1;
    logic [3:0] m, v;

    vecs[0] = '{mask: 4'b1111, din: 4'b1010, word: 4'b1010, lat: 8};
    vecs[1] = '{mask: 4'b0101, din: 4'b1111, word: 4'b0101, lat: 4};
    vecs[2] = '{mask: 4'b0000, din: 4'b1111, word: 4'b0000, lat: 0};
    vecs[3] = '{mask: 4'b1000, din: 4'b1111, word: 4'b1000, lat: 2};
    vecs[4] = '{mask: 4'b1001, din: 4'b0110, word: 4'b0000, lat: 4};
    vecs[5] = '{mask: 4'b0110, din: 4'b0111, word: 4'b0110, lat: 4};

    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    ch_mask    = '0;
    r_in       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel", sel, 2'd0);
    check("rst_word", sample_word, 4'd0);
    check("rst_valid", word_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (sel !== 2'd0 || sample_word !== 4'd0 || word_valid !== 1'b0 || busy !== 1'b0) idle_err++;
    end
    check("idle_stable", idle_err, 0);

    for (int i = 0; i < 6; i++) begin
      run_scan($sformatf("vec%0d", i), vecs[i].mask, vecs[i].din, vecs[i].word, vecs[i].lat);
    end

    // Continuous scan whose mask is narrowed mid-scan, then continuous is dropped.
    @(negedge clk);
    start      = 1'b1;
    continuous = 1'b1;
    ch_mask    = 4'b1111;
    r_in       = 4'b0011;
    @(posedge clk);
    nv = 0; k1 = -1; k2 = -1; w1 = 'x; w2 = 'x; b1 = 'x; b2 = 'x; s1 = 'x;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (word_valid) begin
        if (nv == 0) begin
          k1 = k; w1 = sample_word;
        end else if (nv == 1) begin
          k2 = k; w2 = sample_word; b2 = busy;
        end
        nv++;
      end
      if (k == 8) begin
        b1 = busy; s1 = sel;
      end
      if (k == 0) start = 1'b0;
      if (k == 2) ch_mask = 4'b1000;
      if (k == 9) continuous = 1'b0;
    end
    ch_mask = '0;
    check("cont_words", nv, 2);
    check("cont_lat1", k1, 8);
    check("cont_word1", w1, 4'b0011);
    check("cont_nogap_busy", b1, 1'b1);
    check("cont_nogap_sel", s1, 2'd3);
    check("cont_lat2", k2, 10);
    check("cont_word2", w2, 4'b0000);
    check("cont_busy_end", b2, 1'b0);

    // Reset right after channel 1 has been sampled.
    @(negedge clk);
    start   = 1'b1;
    ch_mask = 4'b1111;
    r_in    = 4'b1111;
    @(posedge clk);
    rv = 0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (word_valid) rv++;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sel", sel, 2'd0);
    check("midrst_valid", word_valid, 1'b0);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (word_valid) rv++;
    end
    check("midrst_no_word", rv, 0);
    run_scan("post_rst", 4'b1111, 4'b0100, 4'b0100, 8);

    // Random scans against the mask-and-data reference.
    for (int i = 0; i < 24; i++) begin
      m = 4'($urandom_range(0, 15));
      v = 4'($urandom_range(0, 15));
      run_scan($sformatf("rnd%0d", i), m, v, m & v, $countones(m) * DW);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
- Sequential controller directly upstream of the 4:1 behavioural mux: drives the mux `sel` and samples the mux's single-bit output.
- Walks the enabled channels in ascending index order, holds each for a programmable dwell time, and samples the bit at the end of the dwell.
- Assembles the samples into a 4-bit word and presents it with a one-cycle valid pulse.
- Supports single-shot and continuous scanning; the channel enable mask is latched per scan.

Parameters:
- DWELL, 2, clock cycles `sel` is held per channel before sampling; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a scan; honoured only in IDLE.
- continuous  input  1  when 1 at end of scan, restart immediately.
- ch_mask  input  4  channel enables, bit i = channel i; latched at scan start.
- mux_out  input  1  output bit of the downstream 4:1 mux.
- sel  output  2  select driven to the mux.
- sample_word  output  4  assembled word, bit i = sample of channel i; masked bits read 0.
- word_valid  output  1  one-cycle pulse; sample_word is new this cycle.
- busy  output  1  high while in SCAN.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, sel=0, sample_word=0, word_valid=0, busy=0, counter=0, shadow accumulator=0, latched mask=0.
- Reset mid-scan: abandon the scan, produce no word_valid, return to IDLE on that edge.
- States: IDLE, SCAN.
- IDLE -> SCAN on the edge where start=1 and latched-next ch_mask != 0. On that edge:
  - mask_q <= ch_mask;
  - sel <= lowest set bit index;
  - cnt <= 0, shadow <= 0, busy <= 1.
- start=1 with ch_mask=0 in IDLE: stay IDLE; pulse word_valid=1 with sample_word=0 the next cycle.
- SCAN dwell: cnt increments each cycle. On the edge where cnt==DWELL-1, shadow[sel] <= mux_out, cnt <= 0.
  - If a higher enabled channel exists in mask_q: sel <= next enabled index.
  - Otherwise (final channel):
    - sample_word <= shadow with bit[sel]=mux_out;
    - word_valid <= 1 for exactly one cycle;
    - shadow <= 0.
- Final channel with continuous=1:
  - mask_q <= current ch_mask.
  - If nonzero: sel <= its lowest index, stay SCAN, no idle gap.
  - If zero: go IDLE, busy <= 0.
- Final channel with continuous=0: IDLE, busy <= 0 on the same edge as word_valid rises; sel holds its last value.
- Latency: word_valid is high in the cycle following edge (N_enabled × DWELL) after the start edge.
  - Example: DWELL=1, mask=1111 gives word_valid 4 edges after start.
- start while busy is ignored; no queuing.
- ch_mask changes during a scan have no effect until the next latch point.
- Disabled channels are never selected and their sample_word bits are 0.
- sel only changes on dwell boundaries, so the mux output is stable for DWELL cycles before each sample.

Decomposition:
- Shared package mux_scan_pkg:
  - state enum {IDLE, SCAN};
  - localparam NUM_CH=4;
  - localparam SEL_W=2.
- One natural combinational sub-module, mux4_next_ch:
  - inputs: mask[3:0], cur[1:0], first flag;
  - outputs: next index and has_next.
  - Used for both first-channel and next-channel lookup.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> sel=0, sample_word=0, word_valid=0, busy=0. Hold start=0 for 10 cycles -> outputs unchanged.
- Single-shot: DWELL=2, mask=1111, mux model in1=4'b1010, pulse start -> sel steps 0,1,2,3 for 2 cycles each. Exactly one word_valid, 8 edges after start, with sample_word=1010; busy falls on the same edge.
- Sparse mask: DWELL=1, mask=0101, in1=4'b1111 -> sel visits only 0 and 2; word_valid after 2 edges with sample_word=0101.
- Continuous with mask change: DWELL=1, continuous=1, mask=1111, in1=0011; switch mask to 1000 mid-scan. Then:
  - first word = 0011;
  - second word = 0000 (bit3 of 0011);
  - no idle gap between scans;
  - dropping continuous ends after the current word.
- Boundaries:
  - start with mask=0000 -> single word_valid, sample_word=0000, busy stays 0.
  - start asserted again while busy -> ignored, only one word produced.
- Reset mid-scan: assert rst after channel 1 is sampled -> no word_valid, IDLE, sel=0. A new start produces a clean full word with no stale bits.
